ifm_bank_scheduler: RTL

- Sequences a ring of NUMBER_OF_BANKS IFM buffer banks between a producer conv stage and a consumer conv stage.
- Tracks bank occupancy and tells the producer which bank to write and whether it may write.
- Issues start pulses to the consumer and selects its read bank; counts consumed banks per layer and flags protocol violations.
- Replaces ad-hoc ping-pong select and start logic between conv control units.

---
 rtl/ifm_bank_scheduler.sv | 117 +++++++++++
 1 files changed

// File: rtl/ifm_bank_scheduler.sv
// Ring sequencer for IFM banks between a producer and a consumer conv stage.
// Selects and flags are registered; prod_ready is decoded from the occupancy register.
module ifm_bank_scheduler #(
  parameter int NUMBER_OF_BANKS = 2,
  parameter int BANKS_PER_LAYER = 16,
  parameter int SEL_W   = (NUMBER_OF_BANKS > 1) ? $clog2(NUMBER_OF_BANKS) : 1,
  parameter int CNT_W   = $clog2(NUMBER_OF_BANKS + 1),
  parameter int LAYER_W = (BANKS_PER_LAYER > 1) ? $clog2(BANKS_PER_LAYER) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             prod_done,
  output logic             prod_ready,
  output logic [SEL_W-1:0] prod_wr_sel,
  input  logic             cons_end,
  input  logic             cons_release,
  output logic             cons_start,
  output logic [SEL_W-1:0] cons_rd_sel,
  output logic [CNT_W-1:0] occupancy,
  output logic             layer_done,
  output logic             protocol_err
);

  typedef enum logic {C_IDLE, C_BUSY} cstate_e;

  localparam logic [SEL_W-1:0]   LAST_BANK  = SEL_W'(NUMBER_OF_BANKS - 1);
  localparam logic [CNT_W-1:0]   FULL_OCC   = CNT_W'(NUMBER_OF_BANKS);
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(BANKS_PER_LAYER - 1);

  cstate_e            state_q, state_d;
  logic [SEL_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [SEL_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   occ_q, occ_d;
  logic [LAYER_W-1:0] layer_cnt_q, layer_cnt_d;
  logic               start_q, start_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               full, rel_acc, prod_acc, start_ok;

  // A release in the same edge frees a slot, so a write at full occupancy is still accepted.
  assign full     = (occ_q == FULL_OCC);
  assign rel_acc  = cons_release && (state_q == C_BUSY);
  assign prod_acc = prod_done && (!full || rel_acc);
  assign start_ok = enable && cons_end && (occ_q != '0);

  always_ff @(posedge clk) begin
    if (reset) state_q <= C_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:  if (start_ok)     state_d = C_BUSY;
      C_BUSY:  if (cons_release) state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  always_comb begin
    start_d = (state_q == C_IDLE) && start_ok;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    layer_cnt_d = layer_cnt_q;
    done_d      = 1'b0;
    if (prod_acc) wr_ptr_d = (wr_ptr_q == LAST_BANK) ? '0 : wr_ptr_q + 1'b1;
    if (rel_acc)  rd_ptr_d = (rd_ptr_q == LAST_BANK) ? '0 : rd_ptr_q + 1'b1;
    case ({prod_acc, rel_acc})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    if (rel_acc) begin
      if (layer_cnt_q == LAST_LAYER) begin
        layer_cnt_d = '0;
        done_d      = 1'b1;
      end else begin
        layer_cnt_d = layer_cnt_q + 1'b1;
      end
    end
    err_d = err_q | (prod_done && !prod_acc) | (cons_release && !rel_acc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      layer_cnt_q <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      layer_cnt_q <= layer_cnt_d;
      start_q     <= start_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign prod_ready   = !full;
  assign prod_wr_sel  = wr_ptr_q;
  assign cons_rd_sel  = rd_ptr_q;
  assign occupancy    = occ_q;
  assign cons_start   = start_q;
  assign layer_done   = done_q;
  assign protocol_err = err_q;

endmodule
